// File: rtl/simon_sequencer_if.sv
// rtl/simon_sequencer_if.sv - game-side signals of simon_sequencer: button pulses in, lamps and status out
interface simon_sequencer_if;
  logic       start;
  logic [3:0] btn_press;
  logic [3:0] lamp;
  logic [4:0] level;
  logic [2:0] phase;
  logic       game_over;
  logic       game_won;

  modport master (
    output start, btn_press,
    input  lamp, level, phase, game_over, game_won
  );

  modport slave (
    input  start, btn_press,
    output lamp, level, phase, game_over, game_won
  );
endinterface

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game controller; the colour sequence is regenerated from an LFSR seed
// on every playback and check pass rather than stored.
module simon_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int TICK_DIV      = 250000,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 20
) (
  input logic              clk,
  input logic              rst,
  simon_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GAP      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    INPUT    = 3'd4,
    ECHO     = 3'd5,
    FAIL     = 3'd6,
    WIN      = 3'd7
  } state_t;

  localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] TAPS = 16'hB400;

  state_t        state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [15:0]   tcnt, tcnt_nx;
  logic [15:0]   seed_ctr, seed, seed_nx, lfsr, lfsr_nx;
  logic [4:0]    idx, idx_nx, level_nx;
  logic [3:0]    lamp_nx;
  logic          tick, done_on, done_off, done_to, idx_last;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign tick     = (pre == PW'(TICK_DIV - 1));
  assign done_on  = tick && (tcnt == 16'(ON_TICKS - 1));
  assign done_off = tick && (tcnt == 16'(OFF_TICKS - 1));
  assign done_to  = tick && (tcnt == 16'(TIMEOUT_TICKS - 1));
  assign idx_last = ({1'b0, idx} + 6'd1) >= {1'b0, bus.level};

  always_comb begin
    state_nx = state;
    seed_nx  = seed;
    lfsr_nx  = lfsr;
    idx_nx   = idx;
    level_nx = bus.level;
    pre_nx   = tick ? '0 : pre + PW'(1);
    tcnt_nx  = tick ? tcnt + 16'd1 : tcnt;
    lamp_nx  = 4'b0000;

    if (bus.start) begin
      seed_nx  = (seed_ctr == 16'h0000) ? 16'h0001 : seed_ctr;
      level_nx = 5'd1;
      idx_nx   = 5'd0;
      state_nx = GAP;
    end else begin
      case (state)
        GAP: if (done_off) begin
          state_nx = SHOW_ON;
          idx_nx   = 5'd0;
          lfsr_nx  = seed;
        end
        SHOW_ON: if (done_on) state_nx = SHOW_OFF;
        SHOW_OFF: if (done_off) begin
          lfsr_nx = lfsr_step(lfsr);
          idx_nx  = idx + 5'd1;
          if (idx_last) begin
            state_nx = INPUT;
            idx_nx   = 5'd0;
            lfsr_nx  = seed;
          end else begin
            state_nx = SHOW_ON;
          end
        end
        // a press landing on the timeout tick still counts as a press
        INPUT: if (bus.btn_press != 4'b0000) begin
          state_nx = (bus.btn_press == onehot(lfsr[1:0])) ? ECHO : FAIL;
        end else if (done_to) begin
          state_nx = FAIL;
        end
        ECHO: if (done_on) begin
          lfsr_nx = lfsr_step(lfsr);
          idx_nx  = idx + 5'd1;
          if (!idx_last) begin
            state_nx = INPUT;
          end else if (bus.level == 5'(MAX_LEN)) begin
            state_nx = WIN;
          end else begin
            state_nx = GAP;
            level_nx = bus.level + 5'd1;
            idx_nx   = 5'd0;
          end
        end
        default: ;
      endcase
    end

    // every state entry (including a restart into GAP) restarts the tick timebase
    if (bus.start || (state_nx != state)) begin
      pre_nx  = '0;
      tcnt_nx = '0;
    end

    case (state_nx)
      SHOW_ON, ECHO: lamp_nx = onehot(lfsr_nx[1:0]);
      FAIL:          lamp_nx = tcnt_nx[0] ? 4'b0000 : 4'b1111;
      WIN:           lamp_nx = onehot(tcnt_nx[1:0]);
      default:       lamp_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seed_ctr <= 16'h0001;
    else     seed_ctr <= seed_ctr + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pre           <= '0;
      tcnt          <= '0;
      seed          <= 16'h0001;
      lfsr          <= 16'h0001;
      idx           <= '0;
      bus.level     <= '0;
      bus.lamp      <= '0;
      bus.phase     <= IDLE;
      bus.game_over <= 1'b0;
      bus.game_won  <= 1'b0;
    end else begin
      state         <= state_nx;
      pre           <= pre_nx;
      tcnt          <= tcnt_nx;
      seed          <= seed_nx;
      lfsr          <= lfsr_nx;
      idx           <= idx_nx;
      bus.level     <= level_nx;
      bus.lamp      <= lamp_nx;
      bus.phase     <= state_nx;
      bus.game_over <= (state_nx == FAIL);
      bus.game_won  <= (state_nx == WIN);
    end
  end
endmodule
